// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types for the bit-serial adder.
//   - state_t   : controller states (IDLE / RUN / DONE); encoding 2'd3 is
//                 unused and recovers to IDLE.
//   - cnt_bits(): width of the bit counter for a given operand width.
// ----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Counter only has to reach width-1, so $clog2(width) bits suffice.
   function automatic int unsigned cnt_bits(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell.
//   Ports:
//     s    out  sum bit        (a ^ b ^ cin)
//     cout out  carry out      (majority of a, b, cin)
//     a    in   operand bit A
//     b    in   operand bit B
//     cin  in   carry in
// ----------------------------------------------------------------------------
module full_adder (
   output logic s,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   logic half_s;

   assign half_s = a ^ b;
   assign s      = half_s ^ cin;
   assign cout   = (a & b) | (cin & half_s);

endmodule

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder built around one full_adder cell (u_fa).
//   Operands are captured on an accepted start, then one bit pair per clock
//   is fed LSB-first into the cell with a registered carry. Sum bits are
//   collected into a working register and transferred to the result
//   registers on the final bit.
//
//   {cout, sum} = a_in + b_in + cin_in  (mod 2^(WIDTH+1))
//   Latency: start accepted at edge E -> done=1 with valid sum/cout after
//   edge E+WIDTH. A start held high through DONE reloads on that edge.
//
//   Parameters:
//     WIDTH   operand/result width, legal range 2..32 (default 8)
//
//   Ports:
//     clk     in   system clock, rising edge
//     rst     in   asynchronous active-high reset
//     start   in   request, sampled only while ready=1
//     a_in    in   operand A, captured on accepted start
//     b_in    in   operand B, captured on accepted start
//     cin_in  in   carry-in, captured on accepted start
//     sub     in   (SERIAL_ADDER_SUB_EN only) 1 = compute a_in - b_in
//     ready   out  1 in IDLE and DONE: start will be accepted
//     busy    out  1 while a bit-serial add is running
//     done    out  one-cycle pulse: sum/cout just updated
//     sum     out  registered result, held until next completion
//     cout    out  registered carry-out of the MSB
//
//   Build option:
//     SERIAL_ADDER_SUB_EN  adds the 'sub' input. With sub=1 the B operand is
//     inverted and the carry seeded with 1, so sum = a_in - b_in and
//     cout=1 means no borrow (cin_in ignored). sub=0 behaves as the plain
//     adder.
// ----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned    CW       = cnt_bits(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;

   logic             accept;
   logic             step;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   // Collected sum bits. Bit 0 of a full-width collector never carries a
   // meaningful value before the final step, so only the upper WIDTH-1
   // positions are stored; work_cat rebuilds the full-width shifted value.
   logic [WIDTH-2:0] work;
   logic [WIDTH-1:0] work_cat;

   logic [WIDTH-1:0] b_load;
   logic             c_load;

   logic             fa_s;
   logic             fa_cout;

   // -------------------------------------------------------------------------
   // Adder cell: one bit pair per RUN cycle, LSB first.
   // -------------------------------------------------------------------------
   full_adder u_fa (
      .s    (fa_s),
      .cout (fa_cout),
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry)
   );

   assign work_cat = {fa_s, work};

   // -------------------------------------------------------------------------
   // Operand load values (subtract = add inverted B with carry seeded to 1).
   // -------------------------------------------------------------------------
   always_comb begin
      b_load = b_in;
      c_load = cin_in;
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) begin
         b_load = ~b_in;
         c_load = 1'b1;
      end
`endif
   end

   // -------------------------------------------------------------------------
   // Controller: state register.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Controller: next state and datapath strobes.
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign ready = (state == S_IDLE) || (state == S_DONE);
   assign busy  = (state == S_RUN);
   assign done  = (state == S_DONE);

   // -------------------------------------------------------------------------
   // Datapath: operand shifters, carry, counter, collector, result.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         work  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sh  <= a_in;
         b_sh  <= b_load;
         carry <= c_load;
         cnt   <= '0;
         work  <= '0;
      end else if (step) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= fa_cout;
         cnt   <= cnt + 1'b1;
         work  <= work_cat[WIDTH-1:1];
         if (last) begin
            sum  <= work_cat;
            cout <= fa_cout;
         end
      end
   end

endmodule
